mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates the single unified RAM port between instruction fetch (icache side) and data access (dcache side) of the pipelined MIPS core.
- Registered grant FSM. Data requests win by default so that memory-stage stalls resolve first.
- Drives the wait handshakes that the hazard and forwarding logic use to freeze pipeline stages.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending (used only with ARB_FAIRNESS_EN).

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  reset, asynchronous, active-low
- iREN  input  1  instruction read request
- iaddr  input  32  instruction address
- iload  output  32  instruction read data
- iwait  output  1  instruction stall
- dREN  input  1  data read request
- dWEN  input  1  data write request
- daddr  input  32  data address
- dstore  input  32  data write value
- dload  output  32  data read data
- dwait  output  1  data stall
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- arb_err  output  1  sticky error flag

Behaviour:
- Clock and reset: one clock, CLK. nRST is asynchronous and active-low.
- Reset values: state=IDLE, arb_err=0, starve count=0.
  - While nRST is low: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=iREN and dwait=dREN|dWEN, so no request completes during reset.
- States: IDLE, IGRANT, DGRANT. State is registered. All outputs are combinational from state and inputs.
- IDLE:
  - No RAM enables asserted.
  - Next state: if dREN|dWEN then DGRANT, else if iREN then IGRANT, else IDLE.
  - Minimum latency: request at cycle N, RAM enables at cycle N+1.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN.
  - If dREN and dWEN are both high, the write wins and arb_err is set.
- IGRANT:
  - ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0.
- Completion:
  - The granted requester's wait output is 0 only in a cycle where ramstate==ACCESS.
  - In that cycle, dload=ramload (or iload=ramload) is valid.
  - The next state re-arbitrates exactly as IDLE does, so back-to-back grants have no bubble.
- Stall rules:
  - A non-granted requester's wait output equals its request.
  - A requester with no request has wait=0.
  - iload and dload are 0 when not completing.
- Request withdrawal: if the granted requester deasserts its request before ACCESS, the enables drop in the same cycle (combinational) and the next state follows the IDLE arbitration rule.
- BUSY/FREE while granted: hold the grant and keep all RAM outputs stable.
- ERROR while granted: treated as BUSY (the grant is held) and arb_err is set. arb_err clears only on reset.
- Simultaneous requests in IDLE: data wins and the fetch waits. After the data ACCESS, the fetch is granted next unless a new data request is present.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Defined:
  - A 3-bit saturating counter increments on each completed data grant while iREN is high.
  - It resets to 0 on each completed instruction grant, or when iREN is low at a data completion.
  - When the counter is at or above STARVE_LIMIT, arbitration favours the fetch over a pending data request for one grant.
- Undefined: the counter is absent and data always has strict priority.

Test Plan:
- Reset: hold nRST=0 with iREN=1, dWEN=1 -> ramREN=0, ramWEN=0, iwait=1, dwait=1, arb_err=0.
- Fetch only:
  - Stimulus: iREN=1, iaddr=0x0000_0040, RAM gives ACCESS two cycles after the grant with ramload=0x2408_0001.
  - Required: ramREN=1 and ramaddr=0x40 from cycle 1; iwait=1 until the ACCESS cycle, then iwait=0 and iload=0x2408_0001.
- Conflict:
  - Stimulus: iREN=1 and dREN=1 (daddr=0x100) raised together.
  - Required: data is served first (ramaddr=0x100); the fetch is granted in the cycle after the data ACCESS with no IDLE bubble; iwait=1 throughout the data access.
- Write:
  - Stimulus: dWEN=1, daddr=0x200, dstore=0xDEAD_BEEF.
  - Required: ramWEN=1, ramstore=0xDEAD_BEEF, ramREN=0; dwait drops on ACCESS.
- Error and withdrawal:
  - ramstate=ERROR during DGRANT -> arb_err=1 and stays 1 after the access completes.
  - Separately, dREN dropped mid-grant -> ramREN=0 that same cycle.
- Fairness (ARB_FAIRNESS_EN, STARVE_LIMIT=4):
  - Stimulus: iREN held and dREN continuously re-asserted.
  - Required: exactly 4 data grants complete, then one instruction grant, then data resumes.

Source files
------------

// File: rtl/mem_arbiter.sv
// Unified RAM port arbiter between instruction fetch and data access; data wins by default.
// Define ARB_FAIRNESS_EN to let a starved fetch win one grant after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        arb_err
);

    typedef enum logic [1:0] {Idle, IGrant, DGrant} state_t;

    localparam logic [1:0] RamAccess = 2'd2;
    localparam logic [1:0] RamError  = 2'd3;

    // The 3-bit starve counter saturates at 7, so a larger limit could never trigger.
    if (STARVE_LIMIT > 7) begin : gBadLimit
        $error("mem_arbiter: STARVE_LIMIT must not exceed 7");
    end

    state_t stateQ, stateD, arbState;
    logic   errQ, errD;
    logic   dReq, dDone, iDone, favourFetch;

    assign dReq  = dREN | dWEN;
    assign dDone = (stateQ == DGrant) && dReq && (ramstate == RamAccess);
    assign iDone = (stateQ == IGrant) && iREN && (ramstate == RamAccess);

`ifdef ARB_FAIRNESS_EN
    logic [2:0] starveQ, starveD;

    always_comb begin
        starveD = starveQ;
        if (dDone) begin
            starveD = iREN ? ((starveQ == 3'd7) ? 3'd7 : starveQ + 3'd1) : 3'd0;
        end else if (iDone) begin
            starveD = 3'd0;
        end
    end

    // Uses the post-completion count so the grant after the limit-reaching access goes to fetch.
    assign favourFetch = (32'(starveD) >= STARVE_LIMIT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starveQ <= 3'd0;
        end else begin
            starveQ <= starveD;
        end
    end
`else
    assign favourFetch = 1'b0;
`endif

    always_comb begin
        arbState = Idle;
        if (favourFetch && iREN) begin
            arbState = IGrant;
        end else if (dReq) begin
            arbState = DGrant;
        end else if (iREN) begin
            arbState = IGrant;
        end
    end

    // Completion and withdrawal both re-arbitrate so back-to-back grants have no bubble.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            Idle:    stateD = arbState;
            DGrant:  if (!dReq || ramstate == RamAccess) stateD = arbState;
            IGrant:  if (!iREN || ramstate == RamAccess) stateD = arbState;
            default: stateD = Idle;
        endcase
    end

    always_comb begin
        errD = errQ;
        if (stateQ == DGrant && dREN && dWEN) errD = 1'b1;
        if (stateQ != Idle && ramstate == RamError) errD = 1'b1;
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0;
        ramstore = 32'h0;
        iwait    = iREN;
        dwait    = dReq;
        iload    = 32'h0;
        dload    = 32'h0;
        unique case (stateQ)
            DGrant: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (dDone) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            IGrant: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (iDone) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stateQ <= Idle;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            errQ   <= errD;
        end
    end

    assign arb_err = errQ;

endmodule
